// File: rtl/detector_jogada_pkg.sv
// Shared definitions for the play detector.
//   estado_t        : FSM state encoding, also shown on the debug display
//   LARGURA_CHAVES  : number of player switches
//   mais_de_um_bit  : true when a switch code has more than one bit set
package detector_jogada_pkg;

  localparam int LARGURA_CHAVES = 4;

  typedef enum logic [1:0] {
    ESPERA         = 2'd0,
    FILTRA_PRESSAO = 2'd1,
    PRESSIONADO    = 2'd2,
    FILTRA_SOLTURA = 2'd3
  } estado_t;

  function automatic logic mais_de_um_bit(input logic [LARGURA_CHAVES-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < LARGURA_CHAVES; i++) begin
      if (v[i]) n++;
    end
    return (n > 1);
  endfunction

endpackage

// File: rtl/detector_jogada_sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous inputs, synchronous active-high reset.
//   clk_i   : clock
//   rst_i   : synchronous reset, clears both stages
//   dado_i  : asynchronous input bus
//   dado_o  : synchronized output bus (two-cycle latency)
module sincronizador_2ff #(
  parameter int LARGURA = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [LARGURA-1:0] dado_i,
  output logic [LARGURA-1:0] dado_o
);

  logic [LARGURA-1:0] estagio1_q;
  logic [LARGURA-1:0] estagio2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      estagio1_q <= '0;
      estagio2_q <= '0;
    end else begin
      estagio1_q <= dado_i;
      estagio2_q <= estagio1_q;
    end
  end

  assign dado_o = estagio2_q;

endmodule

// File: rtl/detector_jogada.sv
// Debounced play detector for four player switches.
// Build option: define JOGADA_SOLTURA_EN to emit the play pulse on filtered
// release instead of on filtered press.
//
// state          | meaning
// ESPERA         | no switch pressed, waiting
// FILTRA_PRESSAO | switches nonzero, waiting for them to settle
// PRESSIONADO    | play accepted and still held
// FILTRA_SOLTURA | switches released, waiting for release to settle
//
// Ports:
//   clock        : single clock, rising edge
//   reset        : synchronous active-high reset
//   chaves       : raw, bouncing player switches
//   jogada       : one-cycle pulse for each accepted play
//   jogada_valor : switch code of the last accepted play
//   pressionado  : high while a play is held
//   multipla     : jogada_valor has more than one bit set
//   db_estado    : zero-extended state code for the debug display
module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [LARGURA_CHAVES-1:0] chaves,
  output logic                      jogada,
  output logic [LARGURA_CHAVES-1:0] jogada_valor,
  output logic                      pressionado,
  output logic                      multipla,
  output logic [3:0]                db_estado
);

  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CW-1:0] CONT_MAX  = CW'(DEBOUNCE_CICLOS);
  localparam logic [CW-1:0] CONT_ALVO = CW'(DEBOUNCE_CICLOS - 1);

  logic [LARGURA_CHAVES-1:0] s_sinc;
  logic [LARGURA_CHAVES-1:0] s_ant_q;
  logic [CW-1:0]             cont_q, cont_d;
  estado_t                   estado_q, estado_d;
  logic [LARGURA_CHAVES-1:0] valor_q, valor_d;
  logic                      jogada_q, jogada_d;
  logic                      mudou;
  logic                      estavel;
  logic                      s_zero;
`ifdef JOGADA_SOLTURA_EN
  logic [LARGURA_CHAVES-1:0] captura_q, captura_d;
`endif

  sincronizador_2ff #(
    .LARGURA(LARGURA_CHAVES)
  ) u_sinc (
    .clk_i (clock),
    .rst_i (reset),
    .dado_i(chaves),
    .dado_o(s_sinc)
  );

  // Filter counter restarts on any change of the synchronized value and
  // saturates so a long-stable input never wraps back into a false "stable".
  always_comb begin
    mudou   = (s_sinc != s_ant_q);
    s_zero  = (s_sinc == '0);
    estavel = !mudou && (cont_q >= CONT_ALVO);
    if (mudou) begin
      cont_d = '0;
    end else if (cont_q == CONT_MAX) begin
      cont_d = cont_q;
    end else begin
      cont_d = cont_q + CW'(1);
    end
  end

  always_comb begin
    estado_d = estado_q;
    valor_d  = valor_q;
    jogada_d = 1'b0;
`ifdef JOGADA_SOLTURA_EN
    captura_d = captura_q;
`endif
    case (estado_q)
      ESPERA: begin
        if (!s_zero) estado_d = FILTRA_PRESSAO;
      end
      FILTRA_PRESSAO: begin
        if (s_zero) begin
          estado_d = ESPERA;
        end else if (estavel) begin
          estado_d = PRESSIONADO;
`ifdef JOGADA_SOLTURA_EN
          captura_d = s_sinc;
`else
          valor_d  = s_sinc;
          jogada_d = 1'b1;
`endif
        end
      end
      PRESSIONADO: begin
        if (s_zero) estado_d = FILTRA_SOLTURA;
      end
      FILTRA_SOLTURA: begin
        if (!s_zero) begin
          estado_d = PRESSIONADO;
        end else if (estavel) begin
          estado_d = ESPERA;
`ifdef JOGADA_SOLTURA_EN
          valor_d  = captura_q;
          jogada_d = 1'b1;
`endif
        end
      end
      default: estado_d = ESPERA;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s_ant_q  <= '0;
      cont_q   <= '0;
      estado_q <= ESPERA;
      valor_q  <= '0;
      jogada_q <= 1'b0;
`ifdef JOGADA_SOLTURA_EN
      captura_q <= '0;
`endif
    end else begin
      s_ant_q  <= s_sinc;
      cont_q   <= cont_d;
      estado_q <= estado_d;
      valor_q  <= valor_d;
      jogada_q <= jogada_d;
`ifdef JOGADA_SOLTURA_EN
      captura_q <= captura_d;
`endif
    end
  end

  assign jogada       = jogada_q;
  assign jogada_valor = valor_q;
  assign multipla     = mais_de_um_bit(valor_q);
  assign pressionado  = (estado_q == PRESSIONADO) || (estado_q == FILTRA_SOLTURA);
  assign db_estado    = {2'b00, estado_q};

endmodule

// File: tb/tb_detector_jogada.sv
module tb_detector_jogada;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] chaves;
  logic       jogada;
  logic [3:0] jogada_valor;
  logic       pressionado;
  logic       multipla;
  logic [3:0] db_estado;

  int n_assert = 0;
  int n_fail   = 0;
  int pulsos   = 0;

  detector_jogada #(.DEBOUNCE_CICLOS(D)) dut (
    .clock       (clock),
    .reset       (reset),
    .chaves      (chaves),
    .jogada      (jogada),
    .jogada_valor(jogada_valor),
    .pressionado (pressionado),
    .multipla    (multipla),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks_conta(input int n);
    repeat (n) begin
      tick();
      if (jogada === 1'b1) pulsos++;
    end
  endtask

  task automatic chk_zerado(input string tag);
    chk({tag, "_jogada"},   8'(jogada),       8'h0);
    chk({tag, "_valor"},    8'(jogada_valor), 8'h0);
    chk({tag, "_press"},    8'(pressionado),  8'h0);
    chk({tag, "_multipla"}, 8'(multipla),     8'h0);
    chk({tag, "_estado"},   8'(db_estado),    8'h0);
  endtask

  initial begin
    reset  = 1'b1;
    chaves = 4'b0100;
    repeat (3) tick();
    chk_zerado("reset");

`ifndef JOGADA_SOLTURA_EN
    // switches held through reset release
    reset  = 1'b0;
    pulsos = 0;
    ticks_conta(6);
    chk("lat_sem_pulso_cedo", 8'(pulsos), 8'd0);
    tick();
    chk("lat_jogada",   8'(jogada),       8'h1);
    chk("lat_valor",    8'(jogada_valor), 8'h4);
    chk("lat_multipla", 8'(multipla),     8'h0);
    chk("lat_press",    8'(pressionado),  8'h1);
    chk("lat_estado",   8'(db_estado),    8'h2);
    pulsos = 0;
    ticks_conta(10);
    chk("pulso_unico", 8'(pulsos), 8'd0);
    chaves = 4'b0000;
    repeat (8) tick();
    chk("solto_estado", 8'(db_estado),    8'h0);
    chk("solto_press",  8'(pressionado),  8'h0);
    chk("solto_valor",  8'(jogada_valor), 8'h4);

    // bounce every 2 cycles never settles
    pulsos = 0;
    for (int i = 0; i < 20; i++) begin
      chaves = (((i / 2) % 2) != 0) ? 4'b0010 : 4'b0000;
      ticks_conta(1);
    end
    chaves = 4'b0000;
    ticks_conta(8);
    chk("bounce_pulsos", 8'(pulsos),       8'd0);
    chk("bounce_estado", 8'(db_estado),    8'h0);
    chk("bounce_valor",  8'(jogada_valor), 8'h4);

    // multi-bit play, then change while held
    chaves = 4'b1001;
    pulsos = 0;
    ticks_conta(6);
    chk("mult_sem_pulso_cedo", 8'(pulsos), 8'd0);
    tick();
    chk("mult_jogada",   8'(jogada),       8'h1);
    chk("mult_valor",    8'(jogada_valor), 8'h9);
    chk("mult_multipla", 8'(multipla),     8'h1);
    chaves = 4'b0001;
    pulsos = 0;
    ticks_conta(12);
    chk("troca_pulsos",   8'(pulsos),       8'd0);
    chk("troca_valor",    8'(jogada_valor), 8'h9);
    chk("troca_multipla", 8'(multipla),     8'h1);
    chk("troca_estado",   8'(db_estado),    8'h2);

    // two plays separated by a 6-cycle release
    chaves = 4'b0000;
    repeat (10) tick();
    chaves = 4'b0001;
    pulsos = 0;
    ticks_conta(7);
    chk("p1_jogada", 8'(jogada),       8'h1);
    chk("p1_valor",  8'(jogada_valor), 8'h1);
    chaves = 4'b0000;
    ticks_conta(6);
    chaves = 4'b1000;
    ticks_conta(7);
    chk("p2_jogada",   8'(jogada),       8'h1);
    chk("p2_pulsos",   8'(pulsos),       8'd2);
    chk("p2_valor",    8'(jogada_valor), 8'h8);
    chk("p2_multipla", 8'(multipla),     8'h0);

    // 2-cycle release is only bounce
    pulsos = 0;
    chaves = 4'b0000;
    ticks_conta(2);
    chaves = 4'b1000;
    ticks_conta(15);
    chk("curta_pulsos", 8'(pulsos),       8'd0);
    chk("curta_valor",  8'(jogada_valor), 8'h8);
    chk("curta_estado", 8'(db_estado),    8'h2);

    // reset while pressed
    chaves = 4'b0010;
    repeat (4) tick();
    chk("pre_rst_estado", 8'(db_estado), 8'h2);
    reset = 1'b1;
    tick();
    chk_zerado("rst_press");
    reset  = 1'b0;
    pulsos = 0;
    ticks_conta(6);
    chk("pos_rst_sem_pulso", 8'(pulsos), 8'd0);
    tick();
    chk("pos_rst_jogada", 8'(jogada),       8'h1);
    chk("pos_rst_valor",  8'(jogada_valor), 8'h2);
    tick();
    chk("pos_rst_fim_pulso", 8'(jogada), 8'h0);
`else
    // play reported on filtered release
    chaves = 4'b0000;
    tick();
    reset  = 1'b0;
    repeat (3) tick();
    chaves = 4'b0100;
    pulsos = 0;
    ticks_conta(10);
    chk("sol_press_pulsos", 8'(pulsos),       8'd0);
    chk("sol_press_estado", 8'(db_estado),    8'h2);
    chk("sol_press_valor",  8'(jogada_valor), 8'h0);
    chk("sol_press_press",  8'(pressionado),  8'h1);
    chaves = 4'b0000;
    ticks_conta(6);
    chk("sol_cedo_pulsos", 8'(pulsos), 8'd0);
    tick();
    chk("sol_jogada",   8'(jogada),       8'h1);
    chk("sol_valor",    8'(jogada_valor), 8'h4);
    chk("sol_multipla", 8'(multipla),     8'h0);
    chk("sol_estado",   8'(db_estado),    8'h0);
    tick();
    chk("sol_fim_pulso", 8'(jogada),       8'h0);
    chk("sol_retem",     8'(jogada_valor), 8'h4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
